// File: rtl/sie_defs_pkg.sv
// Shared SIE definitions: PID codes, handshake bytes, token field
// widths and the packet responder state encoding.
package sie_defs_pkg;

   typedef enum logic [3:0] {
      PID_OUT   = 4'h1,
      PID_ACK   = 4'h2,
      PID_DATA0 = 4'h3,
      PID_PING  = 4'h4,
      PID_SOF   = 4'h5,
      PID_NYET  = 4'h6,
      PID_DATA2 = 4'h7,
      PID_SPLIT = 4'h8,
      PID_IN    = 4'h9,
      PID_NAK   = 4'hA,
      PID_DATA1 = 4'hB,
      PID_PRE   = 4'hC,
      PID_SETUP = 4'hD,
      PID_STALL = 4'hE,
      PID_MDATA = 4'hF
   } pid_e;

   localparam logic [7:0] PID_ACK_BYTE = 8'hD2;
   localparam logic [7:0] PID_NAK_BYTE = 8'h5A;

   localparam int ADDR_W  = 7;
   localparam int ENDP_W  = 4;
   localparam int FRAME_W = 11;

   typedef enum logic [2:0] {
      IDLE,
      RX_TOKEN1,
      RX_TOKEN2,
      RX_DATA,
      RX_DRAIN,
      TX_SEND,
      TX_HOLD
   } rsp_state_e;

   function automatic logic pid_ok(input logic [7:0] b);
      return b[7:4] == ~b[3:0];
   endfunction

endpackage

// File: rtl/usb_crc_strip_fifo.sv
// Fixed-depth delay line: a pushed byte pops the oldest entry once full,
// so the final DEPTH bytes of a packet are never released.
module usb_crc_strip_fifo #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 8,
   localparam int LVL_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             dout_valid,
   output logic [LVL_W-1:0] level
);

   logic [WIDTH-1:0] sr_q [DEPTH];
   logic [WIDTH-1:0] sr_d [DEPTH];
   logic [LVL_W-1:0] level_q, level_d;
   logic             full;

   assign full       = (level_q == LVL_W'(DEPTH));
   assign dout       = sr_q[DEPTH-1];
   assign dout_valid = push && full && !flush;
   assign level      = level_q;

   always_comb begin
      sr_d    = sr_q;
      level_d = level_q;
      if (flush) begin
         level_d = '0;
      end else if (push) begin
         sr_d[0] = din;
         for (int i = 1; i < DEPTH; i++) begin
            sr_d[i] = sr_q[i-1];
         end
         if (!full) begin
            level_d = level_q + LVL_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         level_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            sr_q[i] <= '0;
         end
      end else begin
         level_q <= level_d;
         sr_q    <= sr_d;
      end
   end

endmodule

// File: rtl/usb_packet_responder.sv
// USB device packet responder: parses SIE rx packets, forwards DATA
// payload without CRC16, and answers the host with ACK/NAK.
module usb_packet_responder
   import sie_defs_pkg::*;
#(
   parameter int TX_HOLD_CYCLES = 96,
   parameter int CRC16_BYTES    = 2
) (
   input  logic               clk48,
   input  logic               RST,
   input  logic [ADDR_W-1:0]  deviceAddr,
   input  logic               epNak,
   input  logic [7:0]         rxData,
   input  logic               rxDataValid,
   input  logic               rxIsLastByte,
   input  logic               keepPacket,
   output logic               rxAcceptNewData,
   output logic               txReqSendPacket,
   output logic [7:0]         txData,
   output logic               txDataValid,
   output logic               txIsLastByte,
   input  logic               txAcceptNewData,
   output logic               isSendingPhase,
   output logic               tokenValid,
   output logic [3:0]         tokenPid,
   output logic [ENDP_W-1:0]  tokenEndpoint,
   output logic               sofValid,
   output logic [FRAME_W-1:0] frameNumber,
   output logic [7:0]         dataByte,
   output logic               dataByteValid,
   output logic               dataDone,
   output logic               dataGood
);

   localparam int HOLD_W = $clog2(TX_HOLD_CYCLES);
   localparam int LVL_W  = $clog2(CRC16_BYTES + 1);

   rsp_state_e         state_q, state_d;
   logic               rx_acc_q, rx_acc_d;
   logic               tx_req_q, tx_req_d;
   logic [7:0]         tx_data_q, tx_data_d;
   logic               tx_valid_q, tx_valid_d;
   logic               tx_last_q, tx_last_d;
   logic               sending_q, sending_d;
   logic               tok_valid_q, tok_valid_d;
   logic [3:0]         tok_pid_q, tok_pid_d;
   logic [ENDP_W-1:0]  tok_ep_q, tok_ep_d;
   logic               sof_valid_q, sof_valid_d;
   logic [FRAME_W-1:0] frame_q, frame_d;
   logic [7:0]         data_byte_q, data_byte_d;
   logic               data_valid_q, data_valid_d;
   logic               data_done_q, data_done_d;
   logic               data_good_q, data_good_d;
   logic               addressed_q, addressed_d;
   logic [3:0]         pid_q, pid_d;
   logic [7:0]         byte1_q, byte1_d;
   logic [HOLD_W-1:0]  hold_q, hold_d;

   logic               rx_fire;
   logic               fifo_push;
   logic               fifo_flush;
   logic [7:0]         fifo_dout;
   logic               fifo_dout_valid;
   logic [LVL_W-1:0]   fifo_level;
   logic               pkt_good;

   assign rx_fire    = rxDataValid && rx_acc_q;
   assign fifo_push  = rx_fire && (state_q == RX_DATA);
   assign fifo_flush = (state_q == IDLE);
   assign pkt_good   = keepPacket &&
                       (fifo_level >= LVL_W'(CRC16_BYTES - 1));

   usb_crc_strip_fifo #(
      .DEPTH(CRC16_BYTES),
      .WIDTH(8)
   ) u_strip (
      .clk       (clk48),
      .rst       (RST),
      .flush     (fifo_flush),
      .push      (fifo_push),
      .din       (rxData),
      .dout      (fifo_dout),
      .dout_valid(fifo_dout_valid),
      .level     (fifo_level)
   );

   always_comb begin
      state_d      = state_q;
      tx_req_d     = 1'b0;
      tx_data_d    = tx_data_q;
      tx_valid_d   = tx_valid_q;
      tx_last_d    = tx_last_q;
      sending_d    = sending_q;
      tok_valid_d  = 1'b0;
      tok_pid_d    = tok_pid_q;
      tok_ep_d     = tok_ep_q;
      sof_valid_d  = 1'b0;
      frame_d      = frame_q;
      data_byte_d  = data_byte_q;
      data_valid_d = 1'b0;
      data_done_d  = 1'b0;
      data_good_d  = 1'b0;
      addressed_d  = addressed_q;
      pid_d        = pid_q;
      byte1_d      = byte1_q;
      hold_d       = hold_q;
      unique case (state_q)
         IDLE: begin
            if (rx_fire && !rxIsLastByte) begin
               pid_d = rxData[3:0];
               if (!pid_ok(rxData)) begin
                  state_d = RX_DRAIN;
               end else begin
                  unique case (rxData[3:0])
                     PID_OUT, PID_IN, PID_SETUP, PID_SOF:
                        state_d = RX_TOKEN1;
                     PID_DATA0, PID_DATA1:
                        state_d = (addressed_q &&
                                   (tok_pid_q == PID_OUT ||
                                    tok_pid_q == PID_SETUP)) ?
                                  RX_DATA : RX_DRAIN;
                     default:
                        state_d = RX_DRAIN;
                  endcase
               end
            end
         end
         RX_TOKEN1: begin
            if (rx_fire) begin
               byte1_d = rxData;
               state_d = rxIsLastByte ? IDLE : RX_TOKEN2;
            end
         end
         RX_TOKEN2: begin
            if (rx_fire && !rxIsLastByte) begin
               state_d = RX_DRAIN;
            end else if (rx_fire) begin
               state_d = IDLE;
               if (keepPacket && pid_q == PID_SOF) begin
                  frame_d     = {rxData[2:0], byte1_q};
                  sof_valid_d = 1'b1;
               end else if (keepPacket &&
                            byte1_q[6:0] == deviceAddr) begin
                  tok_pid_d   = pid_q;
                  tok_ep_d    = {rxData[2:0], byte1_q[7]};
                  tok_valid_d = 1'b1;
                  addressed_d = 1'b1;
                  if (pid_q == PID_IN) begin
                     state_d   = TX_SEND;
                     tx_data_d = PID_NAK_BYTE;
                     tx_req_d  = 1'b1;
                     sending_d = 1'b1;
                  end
               end else if (keepPacket) begin
                  addressed_d = 1'b0;
               end
            end
         end
         RX_DATA: begin
            if (rx_fire) begin
               data_valid_d = fifo_dout_valid;
               if (fifo_dout_valid) begin
                  data_byte_d = fifo_dout;
               end
               if (rxIsLastByte) begin
                  data_done_d = 1'b1;
                  data_good_d = pkt_good;
                  addressed_d = 1'b0;
                  state_d     = IDLE;
                  if (pkt_good) begin
                     state_d   = TX_SEND;
                     tx_req_d  = 1'b1;
                     sending_d = 1'b1;
                     tx_data_d = (tok_pid_q == PID_OUT && epNak) ?
                                 PID_NAK_BYTE : PID_ACK_BYTE;
                  end
               end
            end
         end
         RX_DRAIN: begin
            if (rx_fire && rxIsLastByte) begin
               state_d = IDLE;
            end
         end
         TX_SEND: begin
            // request pulse first, then present the byte until taken
            if (tx_req_q) begin
               tx_valid_d = 1'b1;
               tx_last_d  = 1'b1;
            end else if (tx_valid_q && txAcceptNewData) begin
               tx_valid_d = 1'b0;
               tx_last_d  = 1'b0;
               hold_d     = HOLD_W'(TX_HOLD_CYCLES - 1);
               state_d    = TX_HOLD;
            end
         end
         TX_HOLD: begin
            if (hold_q == '0) begin
               sending_d = 1'b0;
               state_d   = IDLE;
            end else begin
               hold_d = hold_q - HOLD_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
      rx_acc_d = !(state_d == TX_SEND || state_d == TX_HOLD);
   end

   always_ff @(posedge clk48) begin
      if (RST) begin
         state_q      <= IDLE;
         rx_acc_q     <= 1'b1;
         tx_req_q     <= 1'b0;
         tx_data_q    <= '0;
         tx_valid_q   <= 1'b0;
         tx_last_q    <= 1'b0;
         sending_q    <= 1'b0;
         tok_valid_q  <= 1'b0;
         tok_pid_q    <= '0;
         tok_ep_q     <= '0;
         sof_valid_q  <= 1'b0;
         frame_q      <= '0;
         data_byte_q  <= '0;
         data_valid_q <= 1'b0;
         data_done_q  <= 1'b0;
         data_good_q  <= 1'b0;
         addressed_q  <= 1'b0;
         pid_q        <= '0;
         byte1_q      <= '0;
         hold_q       <= '0;
      end else begin
         state_q      <= state_d;
         rx_acc_q     <= rx_acc_d;
         tx_req_q     <= tx_req_d;
         tx_data_q    <= tx_data_d;
         tx_valid_q   <= tx_valid_d;
         tx_last_q    <= tx_last_d;
         sending_q    <= sending_d;
         tok_valid_q  <= tok_valid_d;
         tok_pid_q    <= tok_pid_d;
         tok_ep_q     <= tok_ep_d;
         sof_valid_q  <= sof_valid_d;
         frame_q      <= frame_d;
         data_byte_q  <= data_byte_d;
         data_valid_q <= data_valid_d;
         data_done_q  <= data_done_d;
         data_good_q  <= data_good_d;
         addressed_q  <= addressed_d;
         pid_q        <= pid_d;
         byte1_q      <= byte1_d;
         hold_q       <= hold_d;
      end
   end

   assign rxAcceptNewData = rx_acc_q;
   assign txReqSendPacket = tx_req_q;
   assign txData          = tx_data_q;
   assign txDataValid     = tx_valid_q;
   assign txIsLastByte    = tx_last_q;
   assign isSendingPhase  = sending_q;
   assign tokenValid      = tok_valid_q;
   assign tokenPid        = tok_pid_q;
   assign tokenEndpoint   = tok_ep_q;
   assign sofValid        = sof_valid_q;
   assign frameNumber     = frame_q;
   assign dataByte        = data_byte_q;
   assign dataByteValid   = data_valid_q;
   assign dataDone        = data_done_q;
   assign dataGood        = data_good_q;

endmodule

// File: tb/tb_usb_packet_responder.sv
// Randomized bench for usb_packet_responder with a packet-level
// reference model of token, SOF, DATA and handshake behaviour.
module tb_usb_packet_responder;

   localparam int HOLD = 96;

   logic        clk48 = 1'b0;
   logic        RST = 1'b1;
   logic [6:0]  deviceAddr = 7'd5;
   logic        epNak = 1'b0;
   logic [7:0]  rxData = 8'h00;
   logic        rxDataValid = 1'b0;
   logic        rxIsLastByte = 1'b0;
   logic        keepPacket = 1'b0;
   logic        txAcceptNewData = 1'b0;
   logic        rxAcceptNewData, txReqSendPacket, txDataValid;
   logic        txIsLastByte, isSendingPhase, tokenValid, sofValid;
   logic        dataByteValid, dataDone, dataGood;
   logic [7:0]  txData, dataByte;
   logic [3:0]  tokenPid, tokenEndpoint;
   logic [10:0] frameNumber;

   usb_packet_responder #(
      .TX_HOLD_CYCLES(HOLD),
      .CRC16_BYTES(2)
   ) dut (
      .clk48(clk48), .RST(RST), .deviceAddr(deviceAddr),
      .epNak(epNak), .rxData(rxData), .rxDataValid(rxDataValid),
      .rxIsLastByte(rxIsLastByte), .keepPacket(keepPacket),
      .rxAcceptNewData(rxAcceptNewData),
      .txReqSendPacket(txReqSendPacket), .txData(txData),
      .txDataValid(txDataValid), .txIsLastByte(txIsLastByte),
      .txAcceptNewData(txAcceptNewData),
      .isSendingPhase(isSendingPhase), .tokenValid(tokenValid),
      .tokenPid(tokenPid), .tokenEndpoint(tokenEndpoint),
      .sofValid(sofValid), .frameNumber(frameNumber),
      .dataByte(dataByte), .dataByteValid(dataByteValid),
      .dataDone(dataDone), .dataGood(dataGood)
   );

   always #5 clk48 = ~clk48;

   int n_cmp = 0;
   int n_err = 0;

   // event monitor, sampled on the falling edge
   int         tok_cnt = 0, sof_cnt = 0, done_cnt = 0, req_cnt = 0;
   bit         got_good = 1'b0;
   logic [7:0] got_data[$];

   always @(negedge clk48) begin
      if (!RST) begin
         if (tokenValid) tok_cnt++;
         if (sofValid) sof_cnt++;
         if (dataByteValid) got_data.push_back(dataByte);
         if (dataDone) begin
            done_cnt++;
            got_good = dataGood;
         end
         if (txReqSendPacket) req_cnt++;
      end
   end

   // reference model state
   bit         m_addressed;
   logic [3:0] m_tokpid, m_tokep;
   logic [10:0] m_frame;

   task automatic model_reset();
      m_addressed = 1'b0;
      m_tokpid = 4'h0;
      m_tokep = 4'h0;
      m_frame = 11'h0;
   endtask

   task automatic model_packet(input logic [7:0] p[$], input bit keep,
                               output int e_tok, output int e_sof,
                               output logic [7:0] e_data[$],
                               output int e_done, output bit e_good,
                               output logic [7:0] e_hs);
      int n;
      logic [7:0] b0, b1, b2;
      logic [3:0] pid;
      e_tok = 0; e_sof = 0; e_done = 0; e_good = 1'b0; e_hs = 8'h00;
      e_data = {};
      n = p.size();
      if (n < 2) return;
      b0 = p[0];
      if (b0[7:4] != ~b0[3:0]) return;
      pid = b0[3:0];
      if (pid == 4'h1 || pid == 4'h9 || pid == 4'hD || pid == 4'h5) begin
         if (n != 3 || !keep) return;
         b1 = p[1];
         b2 = p[2];
         if (pid == 4'h5) begin
            m_frame = {b2[2:0], b1};
            e_sof = 1;
         end else if (b1[6:0] == deviceAddr) begin
            m_tokpid = pid;
            m_tokep = {b2[2:0], b1[7]};
            m_addressed = 1'b1;
            e_tok = 1;
            if (pid == 4'h9) e_hs = 8'h5A;
         end else begin
            m_addressed = 1'b0;
         end
      end else if (pid == 4'h3 || pid == 4'hB) begin
         if (!(m_addressed && (m_tokpid == 4'h1 || m_tokpid == 4'hD)))
            return;
         e_done = 1;
         e_good = keep && (n - 1 >= 2);
         m_addressed = 1'b0;
         for (int i = 1; i <= n - 3; i++) e_data.push_back(p[i]);
         if (e_good) e_hs = (m_tokpid == 4'h1 && epNak) ? 8'h5A : 8'hD2;
      end
   endtask

   task automatic do_reset();
      @(negedge clk48);
      RST = 1'b1;
      rxDataValid = 1'b0;
      rxIsLastByte = 1'b0;
      txAcceptNewData = 1'b0;
      repeat (3) @(negedge clk48);
      RST = 1'b0;
      model_reset();
   endtask

   task automatic send_packet(input logic [7:0] p[$], input bit keep);
      int g;
      for (int i = 0; i < p.size(); i++) begin
         repeat ($urandom_range(0, 2)) @(negedge clk48);
         rxDataValid = 1'b1;
         rxData = p[i];
         rxIsLastByte = (i == p.size() - 1);
         keepPacket = rxIsLastByte ? keep : 1'($urandom_range(0, 1));
         g = 0;
         while (!rxAcceptNewData && g < 50) begin
            @(negedge clk48);
            g++;
         end
         if (g >= 50) begin
            n_cmp++;
            n_err++;
            $display("FAIL rx_accept_timeout: byte %0d never accepted", i);
         end
         @(negedge clk48);
         rxDataValid = 1'b0;
         rxIsLastByte = 1'b0;
         keepPacket = 1'b0;
      end
   endtask

   // drives one packet and scores every observable outcome against the model
   task automatic run_packet(input logic [7:0] p[$], input bit keep);
      int e_tok, e_sof, e_done, t0, s0, d0, dn0, r0, cnt;
      bit e_good, bad_acc, bad_data;
      logic [7:0] e_data[$];
      logic [7:0] e_hs, first_tx;
      model_packet(p, keep, e_tok, e_sof, e_data, e_done, e_good, e_hs);
      t0 = tok_cnt; s0 = sof_cnt; d0 = got_data.size();
      dn0 = done_cnt; r0 = req_cnt;
      send_packet(p, keep);
      repeat (4) @(negedge clk48);
      n_cmp++;
      if ((tok_cnt - t0) !== e_tok) begin
         n_err++;
         $display("FAIL token_pulses: got %0d want %0d", tok_cnt - t0, e_tok);
      end
      n_cmp++;
      if (tokenPid !== m_tokpid || tokenEndpoint !== m_tokep) begin
         n_err++;
         $display("FAIL token_fields: got pid %0h ep %0h want pid %0h ep %0h", tokenPid, tokenEndpoint, m_tokpid, m_tokep);
      end
      n_cmp++;
      if ((sof_cnt - s0) !== e_sof || frameNumber !== m_frame) begin
         n_err++;
         $display("FAIL sof: got %0d pulses frame %0h want %0d frame %0h", sof_cnt - s0, frameNumber, e_sof, m_frame);
      end
      bad_data = (got_data.size() - d0) != e_data.size();
      if (!bad_data)
         for (int i = 0; i < e_data.size(); i++)
            if (got_data[d0 + i] !== e_data[i]) bad_data = 1'b1;
      n_cmp++;
      if (bad_data) begin
         n_err++;
         $display("FAIL payload: got %0d bytes want %0d bytes (or content differs)", got_data.size() - d0, e_data.size());
      end
      n_cmp++;
      if ((done_cnt - dn0) !== e_done || (e_done == 1 && got_good !== e_good)) begin
         n_err++;
         $display("FAIL data_done: got %0d good %0b want %0d good %0b", done_cnt - dn0, got_good, e_done, e_good);
      end
      if (e_hs == 8'h00) begin
         n_cmp++;
         if ((req_cnt - r0) !== 0 || isSendingPhase !== 1'b0) begin
            n_err++;
            $display("FAIL no_handshake: got req %0d sending %0b want 0 0", req_cnt - r0, isSendingPhase);
         end
         return;
      end
      n_cmp++;
      if ((req_cnt - r0) !== 1 || txDataValid !== 1'b1 || txIsLastByte !== 1'b1 || isSendingPhase !== 1'b1 || rxAcceptNewData !== 1'b0) begin
         n_err++;
         $display("FAIL tx_present: got req %0d valid %0b last %0b send %0b acc %0b want 1 1 1 1 0", req_cnt - r0, txDataValid, txIsLastByte, isSendingPhase, rxAcceptNewData);
      end
      first_tx = txData;
      n_cmp++;
      if (txData !== e_hs) begin
         n_err++;
         $display("FAIL handshake_byte: got %0h want %0h", txData, e_hs);
      end
      repeat ($urandom_range(0, 5)) @(negedge clk48);
      n_cmp++;
      if (txData !== first_tx || txDataValid !== 1'b1) begin
         n_err++;
         $display("FAIL tx_hold_stable: got %0h valid %0b want %0h valid 1", txData, txDataValid, first_tx);
      end
      txAcceptNewData = 1'b1;
      @(posedge clk48);
      @(negedge clk48);
      txAcceptNewData = 1'b0;
      cnt = 0;
      bad_acc = 1'b0;
      while (isSendingPhase === 1'b1 && cnt < 300) begin
         cnt++;
         if (rxAcceptNewData !== 1'b0 || txDataValid !== 1'b0) bad_acc = 1'b1;
         rxDataValid = 1'($urandom_range(0, 1));
         rxData = 8'($urandom);
         @(negedge clk48);
      end
      rxDataValid = 1'b0;
      n_cmp++;
      if (cnt !== HOLD || bad_acc) begin
         n_err++;
         $display("FAIL tx_hold_len: got %0d cycles (accept/valid glitch %0b) want %0d", cnt, bad_acc, HOLD);
      end
   endtask

   task automatic mk_token(input logic [3:0] pid, input logic [6:0] addr,
                           input logic [3:0] ep, output logic [7:0] q[$]);
      logic [4:0] crc;
      crc = 5'($urandom);
      q = {};
      q.push_back({~pid, pid});
      q.push_back({ep[0], addr});
      q.push_back({crc, ep[3:1]});
   endtask

   task automatic mk_data(input bit d1, input int nbytes,
                          output logic [7:0] q[$]);
      q = {};
      q.push_back(d1 ? 8'h4B : 8'hC3);
      for (int i = 0; i < nbytes; i++) q.push_back(8'($urandom));
   endtask

   task automatic test_reset();
      do_reset();
      n_cmp++;
      if (rxAcceptNewData !== 1'b1) begin
         n_err++;
         $display("FAIL reset_rx_accept: got %0b want 1", rxAcceptNewData);
      end
      n_cmp++;
      if ({txReqSendPacket, txDataValid, txIsLastByte, isSendingPhase, tokenValid, sofValid, dataByteValid, dataDone, dataGood} !== 9'h0) begin
         n_err++;
         $display("FAIL reset_flags: got nonzero flags want all 0");
      end
      n_cmp++;
      if ({txData, dataByte, tokenPid, tokenEndpoint, frameNumber} !== 35'h0) begin
         n_err++;
         $display("FAIL reset_fields: got %0h %0h %0h %0h %0h want 0", txData, dataByte, tokenPid, tokenEndpoint, frameNumber);
      end
   endtask

   task automatic test_setup_data();
      logic [7:0] q[$];
      int d0;
      deviceAddr = 7'd5;
      epNak = 1'b0;
      q = '{8'h2D, 8'h05, 8'hE8};
      run_packet(q, 1'b1);
      n_cmp++;
      if (tokenPid !== 4'hD || tokenEndpoint !== 4'h0) begin
         n_err++;
         $display("FAIL setup_token: got pid %0h ep %0h want d 0", tokenPid, tokenEndpoint);
      end
      d0 = got_data.size();
      q = '{8'hC3, 8'h80, 8'h06, 8'hAA, 8'hBB};
      run_packet(q, 1'b1);
      n_cmp++;
      if (got_data.size() != d0 + 2 || got_data[d0] !== 8'h80 || got_data[d0 + 1] !== 8'h06) begin
         n_err++;
         $display("FAIL setup_payload: got %0d bytes want 2 (80 06)", got_data.size() - d0);
      end
   endtask

   task automatic test_out_nak();
      logic [7:0] q[$];
      deviceAddr = 7'd5;
      epNak = 1'b1;
      q = '{8'hE1, 8'h85, 8'hE8};
      run_packet(q, 1'b1);
      n_cmp++;
      if (tokenPid !== 4'h1 || tokenEndpoint !== 4'h1) begin
         n_err++;
         $display("FAIL out_token: got pid %0h ep %0h want 1 1", tokenPid, tokenEndpoint);
      end
      mk_data(1'b1, 5, q);
      run_packet(q, 1'b1);
      q = '{8'hE1, 8'h85, 8'hE8};
      run_packet(q, 1'b1);
      mk_data(1'b1, 5, q);
      run_packet(q, 1'b0);
      epNak = 1'b0;
   endtask

   task automatic test_sof_other_addr();
      logic [7:0] q[$];
      deviceAddr = 7'd5;
      q = '{8'hA5, 8'h34, 8'h02};
      run_packet(q, 1'b1);
      n_cmp++;
      if (frameNumber !== 11'h234) begin
         n_err++;
         $display("FAIL sof_frame: got %0h want 234", frameNumber);
      end
      mk_token(4'hD, 7'd6, 4'h0, q);
      run_packet(q, 1'b1);
      mk_data(1'b0, 4, q);
      run_packet(q, 1'b1);
   endtask

   task automatic test_corrupt_and_in();
      logic [7:0] q[$];
      q = '{8'hC4, 8'h11, 8'h22, 8'h33};
      run_packet(q, 1'b1);
      mk_token(4'h9, deviceAddr, 4'h2, q);
      run_packet(q, 1'b1);
   endtask

   task automatic test_short_data();
      logic [7:0] q[$];
      mk_token(4'hD, deviceAddr, 4'h0, q);
      run_packet(q, 1'b1);
      mk_data(1'b0, 1, q);
      run_packet(q, 1'b1);
      mk_token(4'h1, deviceAddr, 4'h3, q);
      run_packet(q, 1'b1);
      mk_data(1'b0, 2, q);
      run_packet(q, 1'b1);
   endtask

   task automatic test_random();
      logic [7:0] q[$];
      logic [7:0] b;
      int kind, n;
      deviceAddr = 7'($urandom_range(1, 127));
      for (int it = 0; it < 60; it++) begin
         epNak = 1'($urandom_range(0, 1));
         kind = $urandom_range(0, 9);
         if (kind <= 2 || kind == 9) begin
            mk_token($urandom_range(0, 1) ? 4'h1 : 4'hD, deviceAddr, 4'($urandom), q);
            run_packet(q, kind != 9);
            n = ($urandom_range(0, 9) == 0) ? 1 : $urandom_range(2, 8);
            mk_data(1'($urandom_range(0, 1)), n, q);
            run_packet(q, $urandom_range(0, 6) != 0);
         end else if (kind == 3) begin
            mk_token(4'h9, deviceAddr, 4'($urandom), q);
            run_packet(q, 1'b1);
         end else if (kind == 4) begin
            mk_token(4'h1, deviceAddr + 7'($urandom_range(1, 126)), 4'($urandom), q);
            run_packet(q, 1'b1);
            mk_data(1'b0, $urandom_range(2, 6), q);
            run_packet(q, 1'b1);
         end else if (kind == 5) begin
            q = {};
            q.push_back(8'hA5);
            q.push_back(8'($urandom));
            q.push_back(8'($urandom));
            run_packet(q, 1'b1);
         end else if (kind == 6) begin
            do b = 8'($urandom); while (b[7:4] == ~b[3:0]);
            q = {};
            q.push_back(b);
            for (int i = 0; i < $urandom_range(1, 4); i++) q.push_back(8'($urandom));
            run_packet(q, 1'b1);
         end else if (kind == 7) begin
            q = {};
            b = ($urandom_range(0, 1) == 1) ? 8'hD2 : 8'h3C;
            q.push_back(b);
            for (int i = 0; i < $urandom_range(0, 2); i++) q.push_back(8'($urandom));
            run_packet(q, 1'b1);
         end else begin
            mk_data(1'b1, $urandom_range(2, 6), q);
            run_packet(q, 1'b1);
         end
      end
      deviceAddr = 7'd5;
      epNak = 1'b0;
   endtask

   task automatic test_reset_during_tx();
      logic [7:0] q[$];
      int g;
      mk_token(4'h9, deviceAddr, 4'h1, q);
      send_packet(q, 1'b1);
      g = 0;
      while (txReqSendPacket !== 1'b1 && g < 20) begin
         @(negedge clk48);
         g++;
      end
      n_cmp++;
      if (g >= 20) begin
         n_err++;
         $display("FAIL rst_tx_req: got no txReqSendPacket want pulse");
      end
      RST = 1'b1;
      @(posedge clk48);
      #1;
      n_cmp++;
      if (isSendingPhase !== 1'b0 || txDataValid !== 1'b0 || txReqSendPacket !== 1'b0 || rxAcceptNewData !== 1'b1 || tokenPid !== 4'h0) begin
         n_err++;
         $display("FAIL rst_in_tx: got send %0b valid %0b req %0b acc %0b pid %0h want 0 0 0 1 0", isSendingPhase, txDataValid, txReqSendPacket, rxAcceptNewData, tokenPid);
      end
      @(negedge clk48);
      RST = 1'b0;
      model_reset();
      q = '{8'hA5, 8'h77, 8'h05};
      run_packet(q, 1'b1);
   endtask

   initial begin
      test_reset();
      test_setup_data();
      test_out_nak();
      test_sof_other_addr();
      test_corrupt_and_in();
      test_short_data();
      test_random();
      test_reset_during_tx();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/usb_packet_responder.md
Name: usb_packet_responder

Overview:
- Device-side protocol consumer sitting directly above the SIE byte interfaces; the counterpart to the SIE's rx and tx data handshakes.
- Parses received packets (PID check, token/SOF field extraction, DATA payload forwarding with CRC16 stripping).
- Autonomously answers the host with a single-byte handshake packet (ACK/NAK) and owns the SIE isSendingPhase control.

Parameters:
TX_HOLD_CYCLES, 96, clk48 cycles isSendingPhase stays high after the handshake byte is accepted (covers SYNC+PID+stuffing+EOP at 12 Mbit/s)
CRC16_BYTES, 2, trailing CRC bytes the SIE delivers on DATA packets; stripped before forwarding

Ports:
clk48  in  1  system clock
RST  in  1  synchronous active-high reset
deviceAddr  in  7  assigned USB address
epNak  in  1  application not ready: answer OUT/IN with NAK
rxData  in  8  SIE received byte
rxDataValid  in  1  SIE rxData valid
rxIsLastByte  in  1  SIE: current byte ends packet
keepPacket  in  1  SIE: packet error-free (sampled with last byte)
rxAcceptNewData  out  1  ready for SIE byte
txReqSendPacket  out  1  request SIE packet send
txData  out  8  handshake byte
txDataValid  out  1  txData valid
txIsLastByte  out  1  always 1 while txDataValid
txAcceptNewData  in  1  SIE accepts txData
isSendingPhase  out  1  SIE direction select
tokenValid  out  1  1-cycle pulse: token for us decoded
tokenPid  out  4  PID[3:0] of last token (OUT=1, IN=9, SETUP=D)
tokenEndpoint  out  4  endpoint of last token
sofValid  out  1  1-cycle pulse: valid SOF
frameNumber  out  11  SOF frame number
dataByte  out  8  payload byte
dataByteValid  out  1  1-cycle pulse per payload byte
dataDone  out  1  1-cycle pulse at DATA packet end
dataGood  out  1  valid with dataDone: keepPacket && PID ok

Behaviour:
- Reset: all outputs 0 except rxAcceptNewData=1; state IDLE; tokenPid/tokenEndpoint/frameNumber=0; addressed flag cleared. RST mid-transfer aborts immediately; tx request dropped.
- Rx byte transfer occurs on rxDataValid && rxAcceptNewData. rxAcceptNewData=1 in all receive states, 0 in TX states.
- States: IDLE, RX_TOKEN1, RX_TOKEN2, RX_DATA, RX_DRAIN, TX_SEND, TX_HOLD.
- IDLE, first byte = PID. Valid iff rxData[7:4] == ~rxData[3:0]; otherwise go to RX_DRAIN. Single-byte packets (rxIsLastByte on PID) are ignored.
- Token or SOF PID (OUT/IN/SETUP/SOF) → RX_TOKEN1.
  - byte1: addr=[6:0], endp[0]=[7]; SOF frame[7:0]=byte1.
  - byte2: endp[3:1]=[2:0]; SOF frame[10:8]=[2:0]; [7:3] is CRC5 (checked by the SIE).
  - Accept only if byte2 has rxIsLastByte=1 and keepPacket=1. A missing last byte at byte2 → RX_DRAIN.
  - SOF: update frameNumber, pulse sofValid the cycle after byte2.
  - Token with addr==deviceAddr: latch PID/endpoint, pulse tokenValid, set addressed flag. Other address: clear the flag.
  - IN addressed: go to TX_SEND with NAK (0x5A); IN data is out of scope.
- DATA0/DATA1 PID (0xC3/0x4B) → RX_DATA when addressed && tokenPid∈{OUT,SETUP}; else RX_DRAIN.
  - Payload passes through a CRC16_BYTES-deep shift register; a byte is emitted via dataByteValid only once the delay line is full. The trailing 2 bytes are never emitted.
  - On the last byte: pulse dataDone, dataGood=keepPacket, clear the addressed flag.
  - If good: SETUP → ACK (0xD2), OUT → epNak ? NAK (0x5A) : ACK.
  - If bad, or fewer than 2 post-PID bytes (dataGood=0): no handshake, return to IDLE.
- RX_DRAIN: consume bytes until rxIsLastByte, then IDLE.
- Any other PID (handshakes, PRE, etc.) → RX_DRAIN.
- TX_SEND:
  - isSendingPhase=1.
  - First cycle: txReqSendPacket=1 for exactly one cycle.
  - From the next cycle: txDataValid=1, txIsLastByte=1, txData=handshake byte; held stable until txAcceptNewData.
  - After acceptance → TX_HOLD.
- TX_HOLD: counter from TX_HOLD_CYCLES-1 down to 0, then isSendingPhase=0 and IDLE.
- rxDataValid during TX states is ignored (rxAcceptNewData=0).

Decomposition:
- Extend the shared sie_defs_pkg with:
  - PID enum (4-bit), full-byte constants PID_ACK_BYTE=0xD2, PID_NAK_BYTE=0x5A;
  - token field widths (ADDR 7, ENDP 4, FRAME 11);
  - responder state enum.
- Sub-module usb_crc_strip_fifo (parameterised depth delay line with flush) for the payload path.

Test Plan:
- SETUP token A5: bytes 0x2D, 0x05, 0xE8 (last, keep=1) with deviceAddr=5 → tokenValid pulse, tokenPid=D, tokenEndpoint=0.
- Following DATA0: 0xC3, 0x80, 0x06, 0xAA, 0xBB (last, keep=1) → dataByteValid for 0x80, 0x06 only. dataDone with dataGood=1. Then txReqSendPacket pulse and txData=0xD2 until txAcceptNewData; isSendingPhase low exactly 96 cycles after accept.
- OUT to addr 5 ep1 + DATA1 (good) with epNak=1 → txData=0x5A. Same sequence with keepPacket=0 → dataGood=0, no txReqSendPacket.
- SOF 0xA5, 0x34, 0x02 → sofValid, frameNumber=0x234. Token for addr 6 with deviceAddr=5 → no tokenValid; following DATA0 drained, no dataByteValid.
- Corrupt PID 0xC4 followed by 3 bytes → all drained, no outputs.
- IN token addressed to us → NAK sent.
- RST asserted during TX_SEND → next cycle isSendingPhase=0, txDataValid=0, state IDLE.
